// File: rtl/seq_det_prog.sv
// Programmable serial bit-pattern detector: matches a runtime-loaded pattern of 1..PAT_W bits.
// Optional saturating match counter is built when SEQ_DET_CNT_EN is defined.
module seq_det_prog #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             din,
  input  logic             din_valid,
  output logic             armed,
  output logic             dout,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic {
    UNCFG = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             dout_q, dout_d;
  logic             armed_q, armed_d;

  logic [LEN_W-1:0] len_clamp_c;
  logic [PAT_W-1:0] shift_c;
  logic [LEN_W-1:0] fill_inc_c;
  logic [PAT_W-1:0] mask_c;
  logic             match_c;
  logic             hit_c;

  // Lengths beyond PAT_W are treated as PAT_W
  assign len_clamp_c = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;

  // Candidate history after accepting din, and saturating fill count
  assign shift_c    = {hist_q[PAT_W-2:0], din};
  assign fill_inc_c = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);

  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (i < 32'(len_q));
    end
  end

  // Only the low L history bits are compared, and only once L valid bits have arrived
  assign match_c = (fill_inc_c >= len_q) && (((shift_c ^ pat_q) & mask_c) == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (pat_len != '0) ? ARMED : UNCFG;
    end
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    dout_d  = 1'b0;
    hit_c   = 1'b0;
    armed_d = (state_d == ARMED);
    if (clear || cfg_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if ((state_q == ARMED) && din_valid) begin
      hit_c  = match_c;
      dout_d = match_c;
      if (match_c && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shift_c;
        fill_d = fill_inc_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      dout_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      armed_q <= armed_d;
      if (cfg_load) begin
        pat_q <= pattern;
        len_q <= len_clamp_c;
        ovl_q <= overlap;
      end
    end
  end

  assign armed = armed_q;
  assign dout  = dout_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating hit counter; clear dominates a coincident hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (hit_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed scenarios plus randomized traffic
// compared against a bit-queue reference model.
module tb_seq_det_prog;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic             clock;
  logic             reset;
  logic             clear;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             din;
  logic             din_valid;
  logic             armed;
  logic             dout;
  logic [CNT_W-1:0] match_count;

  seq_det_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .cfg_load   (cfg_load),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .overlap    (overlap),
    .din        (din),
    .din_valid  (din_valid),
    .armed      (armed),
    .dout       (dout),
    .match_count(match_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  string phase = "init";

  // Reference model: the valid bits received since the last restart, oldest first
  bit             m_armed;
  int             m_len;
  bit [PAT_W-1:0] m_pat;
  bit             m_ovl;
  int             m_bits[$];
  int             m_cnt;
  bit             exp_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_armed = 1'b0;
    m_len   = 0;
    m_pat   = '0;
    m_ovl   = 1'b0;
    m_bits.delete();
    m_cnt   = 0;
    exp_dout = 1'b0;
  endfunction

  function automatic void model_update(input bit clr, input bit cfg, input bit d, input bit v);
    bit hit;
    exp_dout = 1'b0;
    if (clr) begin
      m_bits.delete();
      m_cnt = 0;
    end
    if (cfg) begin
      m_pat   = pattern;
      m_len   = (int'(pat_len) > PAT_W) ? PAT_W : int'(pat_len);
      m_ovl   = overlap;
      m_armed = (pat_len != 0);
      m_bits.delete();
    end
    if (!clr && !cfg && v && m_armed) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      hit = (m_bits.size() >= m_len);
      for (int k = 0; k < m_len && hit; k++) begin
        if (m_bits[m_bits.size() - 1 - k] != int'(m_pat[k])) hit = 1'b0;
      end
      if (hit) begin
        exp_dout = 1'b1;
`ifdef SEQ_DET_CNT_EN
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
        if (!m_ovl) m_bits.delete();
      end
    end
  endfunction

  // One clock: drive at negedge, update model at posedge, sample at next negedge
  task automatic step(input bit clr, input bit cfg, input bit d, input bit v);
    clear     = clr;
    cfg_load  = cfg;
    din       = d;
    din_valid = v;
    @(posedge clock);
    model_update(clr, cfg, d, v);
    @(negedge clock);
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("armed", 32'(armed), 32'(m_armed));
    chk("count", 32'(match_count), 32'(m_cnt));
    if (dout === 1'b1) pulses++;
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input int len, input bit ovl);
    pattern = p;
    pat_len = LEN_W'(len);
    overlap = ovl;
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send(input bit b);
    step(1'b0, 1'b0, b, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    clear     = 1'b0;
    cfg_load  = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    #2;
    model_reset();
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_armed_hold", 32'(armed), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    pattern = '0;
    pat_len = '0;
    overlap = 1'b0;
    @(negedge clock);
    phase = "reset";
    apply_reset();
    idle();
    send(1'b1);

    phase = "t1_overlap";
    load(8'b1011, 4, 1'b1);
    pulses = 0;
    send(1); send(0); send(1); send(1); send(0); send(1); send(1);
    chk("pulses", 32'(pulses), 32'd2);

    phase = "t2_nonoverlap";
    load(8'b1011, 4, 1'b0);
    pulses = 0;
    send(1); send(0); send(1); send(1); send(0); send(1); send(1);
    chk("pulses", 32'(pulses), 32'd1);

    phase = "t3_zero_pat";
    apply_reset();
    load(8'b0, 3, 1'b1);
    pulses = 0;
    send(0); send(0);
    chk("early", 32'(pulses), 32'd0);
    send(0);
    chk("third", 32'(pulses), 32'd1);
    send(0);
    chk("fourth", 32'(pulses), 32'd2);

    phase = "t4_gaps";
    load(8'b1011, 4, 1'b1);
    pulses = 0;
    send(1); send(0);
    for (int i = 0; i < 5; i++) idle();
    send(1); send(1);
    chk("pulses", 32'(pulses), 32'd1);

    phase = "t5_reset_mid";
    load(8'b1011, 4, 1'b1);
    pulses = 0;
    send(1); send(0); send(1);
    apply_reset();
    load(8'b1011, 4, 1'b1);
    send(1);
    chk("pulses", 32'(pulses), 32'd0);

    phase = "t6_saturate";
    load(8'b1, 1, 1'b1);
    for (int i = 0; i < 5; i++) send(1);
`ifdef SEQ_DET_CNT_EN
    chk("sat_const", 32'(match_count), 32'd3);
`else
    chk("sat_const", 32'(match_count), 32'd0);
`endif
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_const", 32'(match_count), 32'd0);

    phase = "t6_clamp";
    load(8'hA5, 9, 1'b1);
    pulses = 0;
    send(1); send(0); send(1); send(0); send(0); send(1); send(0);
    chk("pre8", 32'(pulses), 32'd0);
    send(1);
    chk("at8", 32'(pulses), 32'd1);

    phase = "t_unarm";
    load(8'h1, 0, 1'b1);
    send(1); send(1);

    phase = "random";
    load(8'b01, 2, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pattern = PAT_W'($urandom);
        pat_len = LEN_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 4));
        overlap = 1'($urandom);
        step(r == 0, 1'b1, 1'($urandom), 1'($urandom));
      end else if (r < 6) begin
        step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
      end else begin
        step(1'b0, 1'b0, 1'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
